// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared encodings and helpers for the memory request arbiter
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_LSB = 1'b0,
        OWN_IC  = 1'b1
    } arb_owner_t;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam logic [1:0] IO_HI = 2'b11;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
    } mem_cmd_t;

    function automatic logic [31:0] len_mask(input logic [2:0] len);
        case (len)
            LEN_B:   return 32'h0000_00FF;
            LEN_H:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of LSB grants taken while icache waits
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic inc,
    output logic full
);
    localparam int             W     = $clog2(MAX + 1);
    localparam logic [W-1:0]   MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en) begin
            if (clr) begin
                cnt <= '0;
            end else if (inc && cnt != MAX_V) begin
                cnt <= cnt + W'(1);
            end
        end
    end

    assign full = (cnt == MAX_V);

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - icache/LSB arbiter for the single memory port; ARB_PERF_CNT_EN adds perf counters
module mem_req_arbiter #(
    parameter int         STARVE_MAX = 4,
    parameter logic [1:0] IO_HI      = mem_req_arbiter_pkg::IO_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        io_buffer_full,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [31:0] lsb_addr,
    input  logic [2:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    output logic        mc_valid,
    output logic        mc_we,
    output logic [31:0] mc_addr,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_ic_grants,
    output logic [31:0] perf_lsb_grants,
    output logic [31:0] perf_io_stall
`endif
);
    import mem_req_arbiter_pkg::*;

    arb_state_t state;
    arb_owner_t owner;
    mem_cmd_t   cmd_r;

    logic lsb_io_blocked;
    logic lsb_elig;
    logic arb_en;
    logic starve_full;
    logic grant_ic;
    logic grant_lsb;
    logic cancel;

    always_comb begin
        lsb_io_blocked = lsb_req && lsb_we && (lsb_addr[17:16] == IO_HI) && io_buffer_full;
        lsb_elig       = lsb_req && !lsb_io_blocked;
        arb_en         = (state == IDLE) && !clr;
        grant_ic       = arb_en && ic_req && (starve_full || !lsb_elig);
        grant_lsb      = arb_en && lsb_elig && !(ic_req && starve_full);
        // A store has already been committed by the ROB, so a flush never drops it.
        cancel         = clr && !(owner == OWN_LSB && cmd_r.we);
    end

    arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk  (clk),
        .rst  (rst),
        .en   (rdy),
        .clr  (clr || !ic_req || grant_ic),
        .inc  (grant_lsb),
        .full (starve_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_LSB;
            cmd_r     <= '0;
            mc_valid  <= 1'b0;
            ic_done   <= 1'b0;
            ic_data   <= '0;
            lsb_done  <= 1'b0;
            lsb_rdata <= '0;
        end else if (rdy) begin
            mc_valid <= 1'b0;
            ic_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ic) begin
                        owner    <= OWN_IC;
                        cmd_r    <= '{we: 1'b0, addr: ic_addr, len: LEN_W, wdata: 32'd0};
                        mc_valid <= 1'b1;
                        state    <= ISSUE;
                    end else if (grant_lsb) begin
                        owner    <= OWN_LSB;
                        cmd_r    <= '{we: lsb_we, addr: lsb_addr, len: lsb_len,
                                      wdata: lsb_we ? lsb_wdata : 32'd0};
                        mc_valid <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= cancel ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (mc_done) begin
                        state <= IDLE;
                        if (!cancel) begin
                            if (owner == OWN_IC) begin
                                ic_done <= 1'b1;
                                ic_data <= mc_rdata;
                            end else begin
                                lsb_done  <= 1'b1;
                                lsb_rdata <= cmd_r.we ? 32'd0 : (mc_rdata & len_mask(cmd_r.len));
                            end
                        end
                    end else if (cancel) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mc_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mc_we    = cmd_r.we;
    assign mc_addr  = cmd_r.addr;
    assign mc_len   = cmd_r.len;
    assign mc_wdata = cmd_r.wdata;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ic_grants  <= '0;
            perf_lsb_grants <= '0;
            perf_io_stall   <= '0;
        end else if (rdy) begin
            if (grant_ic) begin
                perf_ic_grants <= perf_ic_grants + 32'd1;
            end
            if (grant_lsb) begin
                perf_lsb_grants <= perf_lsb_grants + 32'd1;
            end
            if (arb_en && lsb_io_blocked) begin
                perf_io_stall <= perf_io_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - scoreboard bench for mem_req_arbiter
module tb_mem_req_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        lsb_req = 1'b0;
    logic        lsb_we = 1'b0;
    logic [31:0] lsb_addr = '0;
    logic [2:0]  lsb_len = 3'd4;
    logic [31:0] lsb_wdata = '0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        mc_valid;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [2:0]  mc_len;
    logic [31:0] mc_wdata;
    logic        mc_done = 1'b0;
    logic [31:0] mc_rdata = '0;

    mem_req_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .clr            (clr),
        .io_buffer_full (io_buffer_full),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_done        (ic_done),
        .ic_data        (ic_data),
        .lsb_req        (lsb_req),
        .lsb_we         (lsb_we),
        .lsb_addr       (lsb_addr),
        .lsb_len        (lsb_len),
        .lsb_wdata      (lsb_wdata),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata),
        .mc_valid       (mc_valid),
        .mc_we          (mc_we),
        .mc_addr        (mc_addr),
        .mc_len         (mc_len),
        .mc_wdata       (mc_wdata),
        .mc_done        (mc_done),
        .mc_rdata       (mc_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        int          at;
    } cmd_t;

    typedef struct {
        logic        is_ic;
        logic        is_store;
        logic [31:0] data;
        int          at;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    bit          m_busy = 0;
    bit          m_is_ic = 0;
    bit          m_store = 0;
    bit          m_cancel = 0;
    logic [31:0] m_addr = '0;
    logic [2:0]  m_len = 3'd4;
    int          streak = 0;

    // controller model and stimulus knobs
    bit          c_pend = 0;
    int          c_cnt = 0;
    logic [31:0] c_addr = '0;
    int          c_delay = 0;
    bit          ic_auto = 0, lsb_auto = 0, lsb_load_w = 0, io_auto = 0, io_force = 0, clr_next = 0;
    int          p_new = 50, p_clr = 0, p_rdy0 = 0, p_io = 0;
    bit          want_ic = 0, want_lsb = 0;
    logic [31:0] wi_addr = '0, wl_addr = '0, wl_wdata = '0;
    logic        wl_we = 1'b0;
    logic [2:0]  wl_len = 3'd4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        if (a == 32'h100) return 32'h00A0_0093;
        return {a[15:0] ^ 16'hC3A5, a[31:16] + a[15:0]};
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mc_valid"}, 32'(mc_valid), 32'd0);
        chk({tag, "_mc_we"}, 32'(mc_we), 32'd0);
        chk({tag, "_mc_addr"}, mc_addr, 32'd0);
        chk({tag, "_mc_len"}, 32'(mc_len), 32'd0);
        chk({tag, "_mc_wdata"}, mc_wdata, 32'd0);
        chk({tag, "_ic_done"}, 32'(ic_done), 32'd0);
        chk({tag, "_ic_data"}, ic_data, 32'd0);
        chk({tag, "_lsb_done"}, 32'(lsb_done), 32'd0);
        chk({tag, "_lsb_rdata"}, lsb_rdata, 32'd0);
    endtask

    // One arbitration opportunity: winner chosen from the rules, outcome queued.
    task automatic model_cycle();
        bit          g_ic, g_lsb, lsb_ok;
        logic [63:0] m;
        g_ic   = 0;
        g_lsb  = 0;
        lsb_ok = lsb_req && !(lsb_we && lsb_addr[17:16] == 2'b11 && io_buffer_full);
        if (m_busy) begin
            if (clr && !m_store) m_cancel = 1;
            if (mc_done) begin
                m_busy = 0;
                if (!m_cancel) begin
                    m = (64'd1 << (8 * m_len)) - 64'd1;
                    rsp_q.push_back('{m_is_ic, m_store,
                                      m_store ? 32'd0 : (rd_of(m_addr) & m[31:0]), cyc + 1});
                end
            end
        end else if (!clr) begin
            if (ic_req && streak >= STARVE) g_ic = 1;
            else if (lsb_ok)                g_lsb = 1;
            else if (ic_req)                g_ic = 1;
            if (g_ic) begin
                cmd_q.push_back('{1'b0, ic_addr, 3'd4, 32'd0, cyc + 1});
                m_busy = 1; m_is_ic = 1; m_store = 0; m_cancel = 0;
                m_addr = ic_addr; m_len = 3'd4;
            end
            if (g_lsb) begin
                cmd_q.push_back('{lsb_we, lsb_addr, lsb_len, lsb_wdata, cyc + 1});
                m_busy = 1; m_is_ic = 0; m_store = lsb_we; m_cancel = 0;
                m_addr = lsb_addr; m_len = lsb_len;
            end
        end
        if (clr || !ic_req || g_ic) streak = 0;
        else if (g_lsb)            streak = (streak < STARVE) ? streak + 1 : STARVE;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        rdy      = (int'($urandom_range(99)) >= p_rdy0);
        clr      = rdy && (clr_next || (int'($urandom_range(99)) < p_clr));
        clr_next = 0;
        mc_done  = 1'b0;
        mc_rdata = $urandom();
        if (rdy) begin
            if (c_pend) begin
                if (c_cnt == 0) begin
                    mc_done  = 1'b1;
                    mc_rdata = rd_of(c_addr);
                    c_pend   = 0;
                end else begin
                    c_cnt--;
                end
            end
            if (mc_valid) begin
                c_pend = 1;
                c_addr = mc_addr;
                c_cnt  = (c_delay > 0) ? c_delay - 1 : int'($urandom_range(3));
            end
        end
        if (rdy && ic_done)  ic_req = 1'b0;
        if (rdy && lsb_done) lsb_req = 1'b0;
        if (clr) begin
            ic_req = 1'b0;
            if (!lsb_we) lsb_req = 1'b0;
        end
        if (io_auto) begin
            if ($urandom_range(7) == 0) io_buffer_full = ~io_buffer_full;
        end else begin
            io_buffer_full = io_force;
        end
        if (!clr && !ic_req) begin
            if (want_ic) begin
                ic_req = 1'b1; ic_addr = wi_addr; want_ic = 0;
            end else if (ic_auto && int'($urandom_range(99)) < p_new) begin
                ic_req = 1'b1; ic_addr = $urandom() & 32'h0000_3FFC;
            end
        end
        if (!clr && !lsb_req) begin
            if (want_lsb) begin
                lsb_req = 1'b1; lsb_we = wl_we; lsb_addr = wl_addr;
                lsb_len = wl_len; lsb_wdata = wl_wdata; want_lsb = 0;
            end else if (lsb_auto && int'($urandom_range(99)) < p_new) begin
                lsb_req   = 1'b1;
                lsb_we    = lsb_load_w ? 1'b0 : 1'($urandom_range(1));
                lsb_len   = lsb_load_w ? 3'd4 : (($urandom_range(2) == 0) ? 3'd1 :
                                                 ($urandom_range(1) == 0) ? 3'd2 : 3'd4);
                lsb_addr  = (int'($urandom_range(99)) < p_io) ? (32'h0003_0000 | ($urandom() & 32'hFF))
                                                              : ($urandom() & 32'h0000_FFFF);
                lsb_wdata = $urandom();
            end
        end
        if (rdy) model_cycle();
    endtask

    task automatic drain();
        bit quiet;
        ic_auto = 0; lsb_auto = 0; p_clr = 0; p_rdy0 = 0; io_auto = 0; io_force = 0;
        quiet = 0;
        for (int i = 0; i < 400 && !quiet; i++) begin
            step();
            quiet = !ic_req && !lsb_req && !m_busy && !want_ic && !want_lsb;
        end
        repeat (3) step();
        chk("drain_idle", 32'(quiet), 32'd1);
        chk("queues_empty", 32'(cmd_q.size() + rsp_q.size()), 32'd0);
    endtask

    // monitor: pops expectations whenever the DUT presents a command or done pulse
    initial begin
        bit   pv, pi, pl;
        cmd_t c;
        rsp_t r;
        pv = 0; pi = 0; pl = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 0; pi = 0; pl = 0;
            end else begin
                if (mc_valid && !pv) begin
                    if (cmd_q.size() == 0) begin
                        chk("mc_valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("cmd_we", 32'(mc_we), 32'(c.we));
                        chk("cmd_addr", mc_addr, c.addr);
                        chk("cmd_len", 32'(mc_len), 32'(c.len));
                        if (c.we) chk("cmd_wdata", mc_wdata, c.wdata);
                        chk("issue_cycle", 32'(cyc), 32'(c.at));
                    end
                end
                if (ic_done && lsb_done) chk("done_exclusive", 32'd1, 32'd0);
                if (ic_done && !pi) begin
                    if (rsp_q.size() == 0) begin
                        chk("ic_done_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("done_owner_ic", 32'(r.is_ic), 32'd1);
                        chk("ic_data", ic_data, r.data);
                        chk("ic_done_cycle", 32'(cyc), 32'(r.at));
                    end
                end
                if (lsb_done && !pl) begin
                    if (rsp_q.size() == 0) begin
                        chk("lsb_done_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("done_owner_lsb", 32'(r.is_ic), 32'd0);
                        if (!r.is_store) chk("lsb_rdata", lsb_rdata, r.data);
                        chk("lsb_done_cycle", 32'(cyc), 32'(r.at));
                    end
                end
                pv = mc_valid; pi = ic_done; pl = lsb_done;
            end
        end
    end

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // single fetch from 0x100, controller answers four cycles after the command
        c_delay = 4; wi_addr = 32'h100; want_ic = 1;
        repeat (14) step();

        // both requesters saturated with word loads: four LSB grants then one fetch
        c_delay = 0; ic_auto = 1; lsb_auto = 1; p_new = 100; lsb_load_w = 1;
        repeat (80) step();
        lsb_load_w = 0;
        drain();

        // I/O store blocked by a full UART buffer while fetches keep flowing
        io_force = 1; wl_we = 1; wl_addr = 32'h0003_0000; wl_len = 3'd4; wl_wdata = 32'h0000_0041;
        want_lsb = 1; ic_auto = 1; p_new = 100;
        repeat (10) step();
        io_force = 0; ic_auto = 0;
        drain();

        // flush during WAIT of a load, then a fresh request
        c_delay = 4; wl_we = 0; wl_addr = 32'h200; wl_len = 3'd4; want_lsb = 1;
        repeat (3) step();
        clr_next = 1;
        repeat (8) step();
        wi_addr = 32'h500; want_ic = 1;
        drain();

        // flush during WAIT of a store: the store still completes
        wl_we = 1; wl_addr = 32'h300; wl_len = 3'd4; wl_wdata = 32'hDEAD_BEEF; want_lsb = 1;
        repeat (3) step();
        clr_next = 1;
        drain();

        // randomized traffic
        c_delay = 0; ic_auto = 1; lsb_auto = 1; p_new = 50; p_clr = 5; p_rdy0 = 10;
        p_io = 25; io_auto = 1;
        repeat (1500) step();

        // asynchronous reset while a command is outstanding
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            found = m_busy && c_pend;
        end
        chk("reach_wait_for_reset", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        cmd_q.delete(); rsp_q.delete();
        m_busy = 0; streak = 0; c_pend = 0;
        ic_req = 1'b0; lsb_req = 1'b0; clr = 1'b0; mc_done = 1'b0;
        want_ic = 0; want_lsb = 0; ic_auto = 0; lsb_auto = 0; p_clr = 0; p_rdy0 = 0;
        io_auto = 0; io_force = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        wi_addr = 32'h600; want_ic = 1;
        drain();

        // more randomized traffic after reset
        ic_auto = 1; lsb_auto = 1; p_new = 50; p_clr = 5; p_rdy0 = 10; p_io = 25; io_auto = 1;
        repeat (1000) step();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the instruction cache / load-store buffer and the byte-serial memory controller; owns the single memory port.
- Selects one requester per transaction, issues one command, waits for completion, and routes data and done back.
- Handles mispredict flush (`clr`) and the I/O write back-pressure (`io_buffer_full`).
- The memory controller itself stays a pure sequencer.

Parameters:
- STARVE_MAX, 4: consecutive LSB grants allowed while an icache request waits; the next grant is then forced to icache.
- IO_HI, 2'b11: value of addr[17:16] that marks the I/O region.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous reset, active-low (0 = reset); async assert, deassert sampled on clk.
- rdy  in  1  global enable; when 0, all state holds and outputs hold.
- clr  in  1  ROB mispredict flush.
- io_buffer_full  in  1  UART TX buffer full.
- ic_req  in  1  icache fetch request (level, held until ic_done).
- ic_addr  in  32  fetch address.
- ic_done  out  1  one-cycle completion pulse.
- ic_data  out  32  instruction word, valid with ic_done.
- lsb_req  in  1  LSB request (level, held until lsb_done).
- lsb_we  in  1  1 = store, 0 = load.
- lsb_addr  in  32  byte address.
- lsb_len  in  3  bytes: 1, 2 or 4.
- lsb_wdata  in  32  store data, little-endian, low bytes used.
- lsb_done  out  1  one-cycle completion pulse.
- lsb_rdata  out  32  load data zero-extended, valid with lsb_done.
- mc_valid  out  1  one-cycle command pulse to the memory controller.
- mc_we  out  1  command is a write.
- mc_addr  out  32  command address.
- mc_len  out  3  command length.
- mc_wdata  out  32  command write data.
- mc_done  in  1  controller completion pulse.
- mc_rdata  in  32  controller read data, valid with mc_done.

Behaviour:
- Reset: state = IDLE; starve_cnt = 0; owner = LSB; all outputs 0.
- FSM states are IDLE, ISSUE, WAIT, DRAIN.
- IDLE arbitration, priority order:
  - icache wins if ic_req && starve_cnt == STARVE_MAX;
  - else LSB wins if lsb_req;
  - else icache wins if ic_req.
  - The winner's command is latched and the FSM goes to ISSUE.
- I/O write gating:
  - An LSB store with addr[17:16] == IO_HI is not eligible while io_buffer_full = 1.
  - icache may win that cycle instead.
- starve_cnt:
  - +1, saturating at STARVE_MAX, when LSB wins while ic_req = 1.
  - Cleared when icache wins or ic_req = 0.
- ISSUE: mc_valid = 1 for exactly one cycle with the latched fields, then WAIT.
- Latency: request seen in IDLE at cycle t → mc_valid at t+1. mc_done at cycle u → requester done pulse and data at u+1, with the FSM back in IDLE at u+1.
- Back-to-back: a new grant can be made in the IDLE cycle after done.
- WAIT: hold the latched command until mc_done. mc_valid = 0.
- clr handling:
  - In IDLE, clr suppresses arbitration that cycle.
  - In ISSUE or WAIT, clr cancels the owner's result:
    - owner = icache or load → go to DRAIN (from ISSUE, mc_valid is still pulsed first);
    - owner = store → not cancelled; a store is committed and completes normally with lsb_done.
  - clr coincident with mc_done: the result is discarded for icache/load and the FSM returns to IDLE.
- DRAIN: wait for mc_done, discard data, assert no done pulse, return to IDLE. starve_cnt is cleared on clr.
- Done pulses go only to the current owner. ic_done and lsb_done are never high in the same cycle.
- rdy = 0 mid-transaction freezes everything. mc_done is only sampled when rdy = 1.
- Async reset mid-transaction returns to IDLE. The downstream controller is reset by the same rst.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds output ports perf_ic_grants[31:0], perf_lsb_grants[31:0], perf_io_stall[31:0].
  - Grant counters increment on each IDLE grant.
  - perf_io_stall increments each cycle an I/O store is blocked by io_buffer_full.
  - Counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package/define file holds:
  - state encodings (IDLE 2'd0, ISSUE 2'd1, WAIT 2'd2, DRAIN 2'd3);
  - owner encoding (OWN_LSB 1'b0, OWN_IC 1'b1);
  - length codes LEN_B = 3'd1, LEN_H = 3'd2, LEN_W = 3'd4;
  - the IO_HI constant.
- One sub-module is natural: arb_starve_ctr (saturating starvation counter with clear).

Test Plan:
- Single fetch, ic_addr = 0x100, controller returns 0x00A00093 four cycles after mc_valid → mc_valid one cycle after ic_req; ic_done with ic_data = 0x00A00093 one cycle after mc_done.
- ic_req and lsb_req (load, len 4) both held continuously, STARVE_MAX = 4 → grant order LSB, LSB, LSB, LSB, IC, repeating.
- I/O store to 0x30000, io_buffer_full = 1 for 10 cycles, ic_req = 1 → fetches issue during the stall; the store's mc_valid occurs only after io_buffer_full falls.
- clr during WAIT of a load at 0x200 → lsb_done never pulses; after mc_done the FSM returns to IDLE; the next request issues normally.
- clr during WAIT of a store at 0x300, wdata 0xDEADBEEF, len 4 → store completes; lsb_done asserted one cycle after mc_done.
- Assert rst = 0 during WAIT → all outputs 0 immediately; after release, first request issues with latency 1.
